// File: rtl/clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clock_switch_ctrl
//
// Control-side partner of a glitch-free clock mux. It turns an asynchronous
// speed request into a safe switch sequence: wait for the CPU bus to go idle,
// stall the CPU, drive the mux select, then wait for the mux's own
// active0/active1 feedback to confirm the new source. It reports the
// confirmed source and keeps a sticky error if the mux never confirms.
//
// This block must run on the free-running reference clock. Never clock it
// from the muxed output.
//
// Ports
//   clk       in   free-running reference clock
//   rst_n     in   asynchronous reset, active low
//   req_fast  in   requested source (1 = clk1, 0 = clk0); asynchronous
//   bus_idle  in   clk-synchronous; 1 = no CPU bus cycle in progress
//   active0   in   mux feedback, clk0 path enabled; asynchronous
//   active1   in   mux feedback, clk1 path enabled; asynchronous
//   err_clr   in   one-cycle pulse that clears err
//   select    out  mux select (0 = clk0)
//   cpu_hold  out  stalls the CPU while a switch is in progress
//   busy      out  switch sequence in progress
//   cur_fast  out  confirmed current source
//   err       out  sticky: mux failed to confirm within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module clock_switch_ctrl #(
  parameter int SYNC_STAGES    = 2,    // flops per synchronizer, must be >= 2
  parameter int HOLD_CYCLES    = 4,    // cpu_hold lead time before select moves
  parameter int SETTLE_CYCLES  = 8,    // settle time after the mux confirms
  parameter int TIMEOUT_CYCLES = 255,  // max cycles waiting for confirmation
  parameter int CNT_W          = 8     // must hold max(HOLD, SETTLE, TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_fast,
  input  logic bus_idle,
  input  logic active0,
  input  logic active1,
  input  logic err_clr,
  output logic select,
  output logic cpu_hold,
  output logic busy,
  output logic cur_fast,
  output logic err
);

  typedef enum logic [2:0] {
    ST_STABLE,
    ST_WAIT_IDLE,
    ST_HOLD,
    ST_SWITCH,
    ST_SETTLE
  } state_t;

  // Last count value of each timed phase; reaching it ends the phase, so a
  // phase lasts exactly N cycles counting from cnt = 0.
  localparam int HOLD_LAST    = HOLD_CYCLES - 1;
  localparam int SETTLE_LAST  = SETTLE_CYCLES - 1;
  localparam int TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] act0_sync;
  logic [SYNC_STAGES-1:0] act1_sync;
  logic                   req_s;
  logic                   act0_s;
  logic                   act1_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift chain
  // (and the FSM registers below) behave as real flops in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync  <= '0;
      act0_sync <= '0;
      act1_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0],  req_fast};
      act0_sync <= {act0_sync[SYNC_STAGES-2:0], active0};
      act1_sync <= {act1_sync[SYNC_STAGES-2:0], active1};
    end
  end

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign act0_s = act0_sync[SYNC_STAGES-1];
  assign act1_s = act1_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               target_q,   target_d;
  logic               select_q,   select_d;
  logic               hold_q,     hold_d;
  logic               busy_q,     busy_d;
  logic               cur_fast_q, cur_fast_d;
  logic               err_q,      err_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               act_target;
  logic               act_other;

  // Counters saturate rather than wrap.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Confirmation means the target path is on and the other path is off.
  assign act_target = target_q ? act1_s : act0_s;
  assign act_other  = target_q ? act0_s : act1_s;

  // NOTE: every signal written here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    select_d   = select_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    cur_fast_d = cur_fast_q;
    err_d      = err_q;

    // Clear first so a timeout abort in the same cycle overrides it.
    if (err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      ST_STABLE: begin
        // A latched error parks the controller here until err_clr.
        if ((req_s != cur_fast_q) && !err_q) begin
          target_d = req_s;
          busy_d   = 1'b1;
          state_d  = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (req_s == cur_fast_q) begin
          busy_d  = 1'b0;
          state_d = ST_STABLE;
        end else if (bus_idle) begin
          hold_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (int'(cnt_q) >= HOLD_LAST) begin
          select_d = target_q;
          cnt_d    = '0;
          state_d  = ST_SWITCH;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_SWITCH: begin
        if (act_target && !act_other) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (int'(cnt_q) >= TIMEOUT_LAST) begin
          // Give up and steer the mux back to the last confirmed source;
          // cpu_hold stays up through SETTLE so the revert is covered too.
          err_d    = 1'b1;
          select_d = cur_fast_q;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_SETTLE: begin
        if (int'(cnt_q) >= SETTLE_LAST) begin
          cur_fast_d = select_q;
          hold_d     = 1'b0;
          busy_d     = 1'b0;
          state_d    = ST_STABLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  // Async reset drops select at once; the mux performs its own glitch-free
  // return to clk0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STABLE;
      cnt_q      <= '0;
      target_q   <= 1'b0;
      select_q   <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      cur_fast_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      select_q   <= select_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      cur_fast_q <= cur_fast_d;
      err_q      <= err_d;
    end
  end

  assign select   = select_q;
  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign cur_fast = cur_fast_q;
  assign err      = err_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_switch_ctrl
//
// Directed bench for clock_switch_ctrl. A small mux model follows select with
// a three-negedge delay and drives active0/active1; it can be made "dead" so
// that it never confirms a switch. Edge numbers in the comments count rising
// edges after the stimulus change that starts each step.
// -----------------------------------------------------------------------------
module tb_clock_switch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_fast = 1'b0;
  logic bus_idle = 1'b0;
  logic err_clr = 1'b0;
  logic active0;
  logic active1;
  logic select;
  logic cpu_hold;
  logic busy;
  logic cur_fast;
  logic err;

  // Mux model and direct drive for the feedback inputs.
  logic       mux_ok = 1'b0;
  logic       dead   = 1'b0;
  logic       drv_a0 = 1'b0;
  logic       drv_a1 = 1'b0;
  logic       mdl_a0 = 1'b1;
  logic       mdl_a1 = 1'b0;
  logic [2:0] sel_d  = 3'b000;

  int checks   = 0;
  int failures = 0;
  int n;
  logic seen;

  assign active0 = mux_ok ? mdl_a0 : drv_a0;
  assign active1 = mux_ok ? mdl_a1 : drv_a1;

  clock_switch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_fast (req_fast),
    .bus_idle (bus_idle),
    .active0  (active0),
    .active1  (active1),
    .err_clr  (err_clr),
    .select   (select),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .cur_fast (cur_fast),
    .err      (err)
  );

  always #5 clk = ~clk;

  // The mux enables the selected path three clocks after select moves.
  always @(negedge clk) begin
    sel_d = {sel_d[1:0], select};
    if (dead) begin
      mdl_a0 = 1'b1;
      mdl_a1 = 1'b0;
    end else begin
      mdl_a0 = !sel_d[2];
      mdl_a1 = sel_d[2];
    end
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- 1: reset with random inputs, then release with req_fast=0 ----
    for (int i = 0; i < 4; i++) begin
      req_fast = 1'($urandom);
      bus_idle = 1'($urandom);
      drv_a0   = 1'($urandom);
      drv_a1   = 1'($urandom);
      err_clr  = 1'($urandom);
      tick(1);
      chk_n("reset_outputs", int'({select, cpu_hold, busy, cur_fast, err}), 0);
    end
    req_fast = 1'b0;
    bus_idle = 1'b1;
    err_clr  = 1'b0;
    mux_ok   = 1'b1;
    rst_n    = 1'b1;
    tick(5);
    chk_n("post_reset_outputs", int'({select, cpu_hold, busy, cur_fast, err}), 0);

    // ---- 3: request while bus busy, then withdraw ----
    bus_idle = 1'b0;
    req_fast = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (cpu_hold || select) seen = 1'b1;
    end
    chk1("busy_waiting_idle", busy, 1'b1);
    req_fast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (cpu_hold || select) seen = 1'b1;
    end
    chk1("busy_after_withdraw", busy, 1'b0);
    chk1("no_hold_or_select", seen, 1'b0);
    chk1("cur_fast_after_withdraw", cur_fast, 1'b0);

    // ---- 2: slow -> fast with bus idle, exact latencies ----
    bus_idle = 1'b1;
    req_fast = 1'b1;
    tick(3);                                    // edge 3
    chk1("t2_hold_e3", cpu_hold, 1'b0);
    chk1("t2_busy_e3", busy, 1'b1);
    tick(1);                                    // edge 4
    chk1("t2_hold_e4", cpu_hold, 1'b1);
    tick(3);                                    // edge 7
    chk1("t2_select_e7", select, 1'b0);
    tick(1);                                    // edge 8
    chk1("t2_select_e8", select, 1'b1);
    tick(12);                                   // edge 20
    chk1("t2_cur_fast_e20", cur_fast, 1'b0);
    chk1("t2_hold_e20", cpu_hold, 1'b1);
    tick(1);                                    // edge 21
    chk1("t2_cur_fast_e21", cur_fast, 1'b1);
    chk1("t2_hold_e21", cpu_hold, 1'b0);
    chk1("t2_busy_e21", busy, 1'b0);
    chk1("t2_select_e21", select, 1'b1);

    // Back to the slow clock.
    req_fast = 1'b0;
    tick(40);
    chk1("return_slow_cur_fast", cur_fast, 1'b0);
    chk1("return_slow_select", select, 1'b0);
    chk1("return_slow_busy", busy, 1'b0);

    // ---- 6: toggle back during HOLD, both switches serialize ----
    req_fast = 1'b1;
    tick(5);                                    // edge 5, inside HOLD
    req_fast = 1'b0;
    tick(16);                                   // edge 21
    chk1("t6_first_cur_fast", cur_fast, 1'b1);
    chk1("t6_first_busy", busy, 1'b0);
    tick(18);                                   // edge 39
    chk1("t6_second_pending", cur_fast, 1'b1);
    tick(1);                                    // edge 40
    chk1("t6_second_cur_fast", cur_fast, 1'b0);
    chk1("t6_second_select", select, 1'b0);
    chk1("t6_second_busy", busy, 1'b0);

    // ---- 4: dead mux -> timeout, revert, sticky err, err_clr ----
    dead     = 1'b1;
    req_fast = 1'b1;
    tick(8);                                    // edge 8, SWITCH entered
    chk1("t4_select_up", select, 1'b1);
    chk1("t4_hold_up", cpu_hold, 1'b1);
    // err_clr held through SWITCH: no effect while err=0, and the abort
    // edge must still set err.
    err_clr = 1'b1;
    n = 0;
    while (err !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    err_clr = 1'b0;
    chk_n("t4_timeout_cycles", n, 255);
    chk1("t4_err_set", err, 1'b1);
    chk1("t4_select_revert", select, 1'b0);
    chk1("t4_hold_in_settle", cpu_hold, 1'b1);
    tick(7);
    chk1("t4_hold_settle_7", cpu_hold, 1'b1);
    tick(1);
    chk1("t4_hold_released", cpu_hold, 1'b0);
    chk1("t4_cur_fast", cur_fast, 1'b0);
    chk1("t4_busy_done", busy, 1'b0);
    dead = 1'b0;
    tick(20);
    chk1("t4_req_ignored_busy", busy, 1'b0);
    chk1("t4_req_ignored_select", select, 1'b0);
    chk1("t4_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk1("t4_err_cleared", err, 1'b0);
    tick(25);
    chk1("t4_switch_after_clr", cur_fast, 1'b1);
    chk1("t4_err_stays_clear", err, 1'b0);

    // ---- 5: async reset mid-SWITCH ----
    req_fast = 1'b0;
    tick(40);
    chk1("t5_start_slow", cur_fast, 1'b0);
    dead     = 1'b1;
    req_fast = 1'b1;
    tick(10);
    chk1("t5_mid_switch_select", select, 1'b1);
    chk1("t5_mid_switch_hold", cpu_hold, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;                                         // no clock edge in between
    chk1("t5_async_select", select, 1'b0);
    chk1("t5_async_hold", cpu_hold, 1'b0);
    chk1("t5_async_busy", busy, 1'b0);
    chk1("t5_async_cur_fast", cur_fast, 1'b0);
    req_fast = 1'b0;
    dead     = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk_n("t5_after_release", int'({select, cpu_hold, busy, cur_fast, err}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
